// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
//   Bundles the register-file-side signals of the multiply/divide unit.
//
//   master (issuing pipeline / writeback):
//     start, op, busA, busB, wr_hi, wr_lo, wdata  -> unit
//     hi, lo, busy, done                          <- unit
//   slave (muldiv_unit): the reverse directions.
//
//   op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// ----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, busA, busB, wr_hi, wr_lo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, busA, busB, wr_hi, wr_lo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 multiply/divide unit holding the architectural HI/LO
//   registers. Signed operations run on operand magnitudes; the result signs
//   are latched at launch and applied in a single fix-up cycle.
//
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    muldiv_unit_if.slave
//              start/op/busA/busB : launch MULT/MULTU/DIV/DIVU (idle only)
//              wr_hi/wr_lo/wdata  : MTHI/MTLO (idle only)
//              hi/lo              : HI/LO registers
//              busy/done          : operation in progress / completion pulse
//
//   Latency: start sampled at edge 0 -> WIDTH iteration edges -> FIX at
//   edge WIDTH+1 writes HI/LO, pulses done and drops busy.
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state;
    logic               is_div_q;   // latched op[1]
    logic               neg_q;      // product / quotient sign
    logic               rneg_q;     // remainder sign (dividend sign)
    logic               dz_q;       // divide by zero
    logic [WIDTH-1:0]   araw_q;     // busA as latched, for divide by zero
    logic [WIDTH-1:0]   m_q;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // mult: {partial, multiplier}; div: {rem, quo}
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    // ------------------------------------------------------------------
    // Launch-time operand conditioning
    // ------------------------------------------------------------------
    logic             in_signed;
    logic             in_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        in_signed = ~bus.op[0];
        in_div    = bus.op[1];
        a_neg     = in_signed & bus.busA[WIDTH-1];
        b_neg     = in_signed & bus.busB[WIDTH-1];
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude, so no special case is needed.
        a_mag     = a_neg ? -bus.busA : bus.busA;
        b_mag     = b_neg ? -bus.busB : bus.busB;
    end

    // ------------------------------------------------------------------
    // Iteration step datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Shift-add: conditionally add the multiplicand into the upper half
        // (keeping the carry), then shift the whole accumulator right.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder
        // and keep the difference only when it does not go negative.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_ge    = (div_shift >= {1'b0, m_q});
        div_next  = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                           : {acc[2*WIDTH-2:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_q  ? -acc : acc;
        quo_fix  = neg_q  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Control FSM and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            araw_q   <= '0;
            m_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    // MTHI/MTLO land now even if an operation launches on
                    // the same edge; FIX overwrites both later.
                    if (bus.wr_hi) hi_q <= bus.wdata;
                    if (bus.wr_lo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        is_div_q <= in_div;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        dz_q     <= in_div & (bus.busB == '0);
                        araw_q   <= bus.busA;
                        // Multiply runs multiplier bits out of the low half;
                        // divide runs dividend bits out of the low half.
                        m_q      <= in_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= CALC;
                    end
                end

                CALC: begin
                    acc <= is_div_q ? div_next : mul_next;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_q <= araw_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (WIDTH = 32). Expected HI/LO values are
//   computed from native 64-bit arithmetic when an operation is issued and
//   popped when the unit reports done.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus_if ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];

    // Reference result {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, q, r;
        logic [63:0] res;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        res = '0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Drive start for one edge from a point #1 after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus_if.op    = op;
        bus_if.busA  = a;
        bus_if.busB  = b;
        bus_if.start = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(posedge clock);
        #1;
        bus_if.start = 1'b0;
    endtask

    // Count edges until done; -1 if the bound expires.
    task automatic wait_done(output int edges, output bit busy_ok);
        edges   = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock);
            #1;
            if (bus_if.done) begin
                edges = n;
                break;
            end
            if (!bus_if.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done} !== '0) begin
            errors++;
            $display("FAIL reset_in: got hi=%h lo=%h busy=%b done=%b required all zero",
                     bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done} !== '0) begin
            errors++;
            $display("FAIL reset_after: got hi=%h lo=%h busy=%b done=%b required all zero",
                     bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done);
        end
    endtask

    task automatic test_mult();
        logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h1234_5678, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h9ABC_DEF0, 32'h8000_0000};
        logic [63:0] exp;
        int          n;
        bit          bok;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(n, bok);
            exp = exp_q.pop_front();
            checks++;
            if (n != LAT) begin
                errors++;
                $display("FAIL mult_latency[%0d]: got %0d edges required %0d", i, n, LAT);
            end
            checks++;
            if (!bok) begin
                errors++;
                $display("FAIL mult_busy[%0d]: busy dropped before done, required 1", i);
            end
            checks++;
            if ({bus_if.hi, bus_if.lo} !== exp) begin
                errors++;
                $display("FAIL mult_result[%0d]: got %h_%h required %h_%h", i,
                         bus_if.hi, bus_if.lo, exp[63:32], exp[31:0]);
            end
            @(posedge clock);
            #1;
            checks++;
            if (bus_if.done !== 1'b0) begin
                errors++;
                $display("FAIL mult_done_pulse[%0d]: got done=%b required 0", i, bus_if.done);
            end
        end
    endtask

    task automatic test_div();
        logic [1:0]  ops [7] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [31:0] as  [7] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7,
                                 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] bs  [7] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFE, 32'd10, 32'd9};
        logic [63:0] exp;
        int          n;
        bit          bok;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(n, bok);
            exp = exp_q.pop_front();
            checks++;
            if (n != LAT || !bok) begin
                errors++;
                $display("FAIL div_timing[%0d]: got %0d edges busy_ok=%b required %0d edges busy_ok=1",
                         i, n, bok, LAT);
            end
            checks++;
            if ({bus_if.hi, bus_if.lo} !== exp) begin
                errors++;
                $display("FAIL div_result[%0d]: got hi=%h lo=%h required hi=%h lo=%h", i,
                         bus_if.hi, bus_if.lo, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [1:0]  ops [3] = '{2'b11, 2'b10, 2'b10};
        logic [31:0] as  [3] = '{32'h0000_1234, 32'h8000_0005, 32'd77};
        logic [63:0] exp;
        int          n;
        bit          bok;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], 32'd0);
            wait_done(n, bok);
            exp = exp_q.pop_front();
            checks++;
            if (n != LAT) begin
                errors++;
                $display("FAIL divzero_latency[%0d]: got %0d edges required %0d", i, n, LAT);
            end
            checks++;
            if ({bus_if.hi, bus_if.lo} !== exp) begin
                errors++;
                $display("FAIL divzero_result[%0d]: got hi=%h lo=%h required hi=%h lo=%h", i,
                         bus_if.hi, bus_if.lo, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] hi_before;
        hi_before     = bus_if.hi;
        bus_if.wr_lo  = 1'b1;
        bus_if.wdata  = 32'hA5A5_A5A5;
        @(posedge clock);
        #1;
        bus_if.wr_lo  = 1'b0;
        checks++;
        if (bus_if.lo !== 32'hA5A5_A5A5 || bus_if.hi !== hi_before) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h required hi=%h lo=a5a5a5a5",
                     bus_if.hi, bus_if.lo, hi_before);
        end
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_flags: got done=%b busy=%b required 0 0", bus_if.done, bus_if.busy);
        end
        bus_if.wr_hi  = 1'b1;
        bus_if.wdata  = 32'h5A5A_0F0F;
        @(posedge clock);
        #1;
        bus_if.wr_hi  = 1'b0;
        checks++;
        if (bus_if.hi !== 32'h5A5A_0F0F || bus_if.lo !== 32'hA5A5_A5A5 || bus_if.done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h lo=%h done=%b required hi=5a5a0f0f lo=a5a5a5a5 done=0",
                     bus_if.hi, bus_if.lo, bus_if.done);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] hi_before;
        logic [63:0] exp;
        int          n;
        bit          bok;
        bit          quiet;
        issue(2'b00, 32'd123456, 32'hFFFF_FCEB);   // 123456 * -789
        hi_before = bus_if.hi;
        repeat (5) @(posedge clock);
        #1;
        bus_if.start = 1'b1;
        bus_if.op    = 2'b11;
        bus_if.busA  = 32'hDEAD_BEEF;
        bus_if.busB  = 32'd3;
        bus_if.wr_hi = 1'b1;
        bus_if.wdata = 32'hCAFE_F00D;
        @(posedge clock);
        #1;
        bus_if.start = 1'b0;
        bus_if.wr_hi = 1'b0;
        checks++;
        if (bus_if.hi !== hi_before) begin
            errors++;
            $display("FAIL busy_mthi: got hi=%h required %h", bus_if.hi, hi_before);
        end
        wait_done(n, bok);
        exp = exp_q.pop_front();
        checks++;
        if (n != LAT - 6) begin
            errors++;
            $display("FAIL busy_latency: got %0d edges required %0d", n, LAT - 6);
        end
        checks++;
        if ({bus_if.hi, bus_if.lo} !== exp) begin
            errors++;
            $display("FAIL busy_result: got %h_%h required %h_%h",
                     bus_if.hi, bus_if.lo, exp[63:32], exp[31:0]);
        end
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus_if.busy || bus_if.done) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL busy_no_relaunch: got activity after done required none");
        end
    endtask

    task automatic test_start_with_write();
        logic [63:0] exp;
        int          n;
        bit          bok;
        bus_if.wr_lo = 1'b1;
        bus_if.wdata = 32'h1111_2222;
        issue(2'b01, 32'd3, 32'd4);
        bus_if.wr_lo = 1'b0;
        checks++;
        if (bus_if.lo !== 32'h1111_2222 || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_write: got lo=%h busy=%b required lo=11112222 busy=1",
                     bus_if.lo, bus_if.busy);
        end
        wait_done(n, bok);
        exp = exp_q.pop_front();
        checks++;
        if (n != LAT || {bus_if.hi, bus_if.lo} !== exp) begin
            errors++;
            $display("FAIL start_write_result: got %0d edges %h_%h required %0d edges %h_%h",
                     n, bus_if.hi, bus_if.lo, LAT, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        logic [31:0] b;
        int          n;
        bit          bok;
        b = $urandom;
        issue(2'($urandom_range(0, 3)), $urandom, b);
        for (int i = 0; i < 5; i++) begin
            wait_done(n, bok);
            exp = exp_q.pop_front();
            checks++;
            if (n != LAT || !bok) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: got %0d edges busy_ok=%b required %0d edges busy_ok=1",
                         i, n, bok, LAT);
            end
            checks++;
            if ({bus_if.hi, bus_if.lo} !== exp) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got %h_%h required %h_%h", i,
                         bus_if.hi, bus_if.lo, exp[63:32], exp[31:0]);
            end
            if (i < 4) begin
                b = (i == 1) ? 32'd0 : ((i == 2) ? 32'($urandom_range(1, 255)) : $urandom);
                issue(2'($urandom_range(0, 3)), $urandom, b);
                checks++;
                if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_accept[%0d]: got busy=%b done=%b required 1 0",
                             i, bus_if.busy, bus_if.done);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp;
        int          n;
        bit          bok;
        bus_if.wr_hi = 1'b1;
        bus_if.wr_lo = 1'b1;
        bus_if.wdata = 32'h0000_0F0F;
        @(posedge clock);
        #1;
        bus_if.wr_hi = 1'b0;
        bus_if.wr_lo = 1'b0;
        issue(2'b10, 32'hFFFF_FF9C, 32'd7);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got hi=%h lo=%h busy=%b done=%b required all zero",
                     bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        repeat (40) @(posedge clock);
        #1;
        checks++;
        if ({bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_abort: got hi=%h lo=%h busy=%b done=%b required all zero",
                     bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done);
        end
        issue(2'b00, 32'd6, 32'd7);
        wait_done(n, bok);
        exp = exp_q.pop_front();
        checks++;
        if (n != LAT || bus_if.lo !== 32'd42 || {bus_if.hi, bus_if.lo} !== exp) begin
            errors++;
            $display("FAIL reset_mid_recover: got %0d edges hi=%h lo=%h required %0d edges hi=%h lo=%h",
                     n, bus_if.hi, bus_if.lo, LAT, exp[63:32], exp[31:0]);
        end
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.busA  = '0;
        bus_if.busB  = '0;
        bus_if.wr_hi = 1'b0;
        bus_if.wr_lo = 1'b0;
        bus_if.wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_mthi_mtlo();
        test_busy_ignore();
        test_start_with_write();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the MIPS datapath, directly downstream of the register file. Consumes the two register read buses (`busA`, `busB`) for MULT/MULTU/DIV/DIVU and holds the result in the architectural HI/LO registers. Writeback logic reads `hi`/`lo` for MFHI/MFLO, and MTHI/MTLO write them directly. The unit uses a radix-2 shift-add / shift-subtract datapath and signals completion with `busy`/`done`.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch an operation. Sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `busA`  in  WIDTH  rs operand (multiplicand / dividend).
- `busB`  in  WIDTH  rt operand (multiplier / divisor).
- `wr_hi`  in  1  MTHI strobe.
- `wr_lo`  in  1  MTLO strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: `WIDTH` iteration cycles.
  - FIX: one cycle for sign correction and HI/LO writeback.
- IDLE→CALC on `start`=1:
  - Latch `op`.
  - For signed ops, latch operand magnitudes plus the result signs: product sign = sign(A) xor sign(B); quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Clear the iteration counter.
- CALC:
  - MULT/MULTU: one shift-add step per cycle over a 2·WIDTH accumulator.
  - DIV/DIVU: one restoring shift-subtract step per cycle.
  - Counter runs 0..WIDTH-1, then goes to FIX.
- FIX:
  - Apply two's-complement negation per the latched signs.
  - Write HI/LO. Multiply: HI = upper half of the product, LO = lower half. Divide: LO = quotient, HI = remainder.
  - Then go to IDLE.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude datapath with no special case.
- Divide by zero (both DIV and DIVU): full latency, LO=all-ones, HI=`busA` as latched (raw bits).
- MTHI/MTLO:
  - While `busy`=0: `wr_hi`/`wr_lo` load `wdata` into HI/LO at the clock edge.
  - While `busy`=1: ignored.
- `start` while `busy`=1: ignored; operands are not re-latched.
- `start` together with `wr_hi`/`wr_lo` in IDLE: both take effect. The write lands immediately; the operation overwrites HI and LO in FIX.
- HI/LO hold their value at all other times.

## Timing
- Reset (`reset`=0, asynchronous):
  - State=IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - All internal accumulators and the counter are cleared.
  - Reset mid-operation aborts it; no partial result reaches HI/LO.
- Let `start` be sampled at edge 0:
  - `busy`=1 from edge 0 through edge WIDTH+1.
  - At edge WIDTH+1 (FIX edge): `hi`/`lo` take the result, `done`=1 and `busy`=0 for one cycle.
  - Total latency is WIDTH+1 edges (33 for WIDTH=32).
- A new `start` may be issued in the `done` cycle. It is accepted at the next edge with no bubble.
- `done` never asserts for MTHI/MTLO writes.
- `hi`/`lo` are register outputs; no combinational path from inputs to outputs.

## Test plan
- MULT `busA`=0xFFFFFFFD (-3), `busB`=5 → after 33 edges `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `done` high exactly one cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; MULT of the same operands → `hi`=0, `lo`=1.
- DIV -7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x1234/0 → `lo`=0xFFFFFFFF, `hi`=0x00001234 after full latency.
- MTLO 0xA5A5A5A5 in IDLE → `lo` updated next edge, `done` stays 0. During an active MULT, `start`/`wr_hi` are pulsed → no effect; the MULT result is correct.
- `reset` pulled low at iteration 10 of a DIV → immediately `busy`=0, `hi`=`lo`=0. After release, a new MULT 6×7 gives `lo`=42 in 33 edges.
